score_board: RTL and testbench

SCORE_BOARD -- requirements
Module: score_board

---
 rtl/score_board_pkg.sv | 39 +++
 rtl/score_board_lookup.sv | 50 +++++
 rtl/score_board.sv | 74 +++++++
 tb/tb_score_board.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/score_board_pkg.sv
// rtl/score_board_pkg.sv - shared types and helpers for the issue-stage score board
// Purpose: register-address width, source encoding, per-query result and
//          per-stage entry types, plus a valid-bit count helper.
// Ports:   none (package).
package score_board_pkg;

  localparam int REG_ADDR = 5;

  typedef logic [REG_ADDR-1:0] reg_addr_t;

  // Where the freshest value of a source register lives.
  typedef enum logic [1:0] {
    SB_REGFILE = 2'd0,
    SB_EX      = 2'd1,
    SB_MEM     = 2'd2,
    SB_CMT     = 2'd3
  } sb_src_e;

  // Bypass-facing lookup result; bit layout is {src[1:0], slot, ready}.
  typedef struct packed {
    sb_src_e src;
    logic    slot;
    logic    ready;
  } score_board_data_t;

  // One in-flight write in a pipeline stage.
  typedef struct packed {
    logic      valid;
    reg_addr_t dest;
    logic      is_load;
  } sb_entry_t;

  localparam score_board_data_t SB_DATA_REGFILE = '{src: SB_REGFILE, slot: 1'b0, ready: 1'b1};

  function automatic logic [2:0] stage_valid_count(input sb_entry_t [1:0] stage);
    return 3'(stage[0].valid) + 3'(stage[1].valid);
  endfunction

endpackage

// File: rtl/score_board_lookup.sv
// rtl/score_board_lookup.sv - youngest-first priority search for one source operand
// Purpose: combinational search of EX, MEM and CMT entries for one query address.
// Ports:   enable     - 0 forces the regfile answer (used while in reset)
//          query_addr - source register being looked up
//          ex_stage, mem_stage, cmt_stage - current stage contents, 2 slots each
//          result     - {src, slot, ready}
module score_board_lookup
  import score_board_pkg::*;
(
  input  logic              enable,
  input  reg_addr_t         query_addr,
  input  sb_entry_t [1:0]   ex_stage,
  input  sb_entry_t [1:0]   mem_stage,
  input  sb_entry_t [1:0]   cmt_stage,
  output score_board_data_t result
);

  function automatic logic hit(input sb_entry_t e, input reg_addr_t a);
    return e.valid && (e.dest == a);
  endfunction

  always_comb begin
    result = SB_DATA_REGFILE;
    // r0 is hardwired; never report a producer for it.
    if (enable && (query_addr != '0)) begin
      if (hit(ex_stage[1], query_addr)) begin
        result.src   = SB_EX;
        result.slot  = 1'b1;
        result.ready = ~ex_stage[1].is_load;
      end else if (hit(ex_stage[0], query_addr)) begin
        result.src   = SB_EX;
        result.slot  = 1'b0;
        result.ready = ~ex_stage[0].is_load;
      end else if (hit(mem_stage[1], query_addr)) begin
        result.src  = SB_MEM;
        result.slot = 1'b1;
      end else if (hit(mem_stage[0], query_addr)) begin
        result.src  = SB_MEM;
        result.slot = 1'b0;
      end else if (hit(cmt_stage[1], query_addr)) begin
        result.src  = SB_CMT;
        result.slot = 1'b1;
      end else if (hit(cmt_stage[0], query_addr)) begin
        result.src  = SB_CMT;
        result.slot = 1'b0;
      end
    end
  end

endmodule

// File: rtl/score_board.sv
// rtl/score_board.sv - dual-issue score board tracking writes in EX, MEM and CMT
// Purpose: mirror the destination writes flowing through the three post-issue
//          stages and tell each of four source operands where its value lives.
// Ports:   clk, rst (sync, active-low)
//          issue_ena/issue_wen/issue_dest/issue_is_load - per-slot issue info
//          flush            - drop every in-flight entry at the next edge
//          query_addr       - 4 source registers, index = 2*slot + operand
//          score_board_data - 4 lookup results {src, slot, ready}
//          inflight_count   - registered count of valid entries (0..6)
module score_board
  import score_board_pkg::*;
(
  input  logic                           clk,
  input  logic                           rst,
  input  logic [1:0]                     issue_ena,
  input  logic [1:0]                     issue_wen,
  input  logic [1:0][REG_ADDR-1:0]       issue_dest,
  input  logic [1:0]                     issue_is_load,
  input  logic                           flush,
  input  logic [3:0][REG_ADDR-1:0]       query_addr,
  output score_board_data_t [3:0]        score_board_data,
  output logic [2:0]                     inflight_count
);

  sb_entry_t [1:0] ex_q,  ex_d;
  sb_entry_t [1:0] mem_q, mem_d;
  sb_entry_t [1:0] cmt_q, cmt_d;
  logic [2:0]      count_q, count_d;

  always_comb begin
    ex_d  = '0;
    mem_d = ex_q;
    cmt_d = mem_q;
    for (int i = 0; i < 2; i++) begin
      // Writes to r0 are discarded, so they never become a hazard.
      ex_d[i].valid   = issue_ena[i] & issue_wen[i] & (issue_dest[i] != '0) & ~flush;
      ex_d[i].dest    = issue_dest[i];
      ex_d[i].is_load = issue_is_load[i];
      if (flush) begin
        mem_d[i].valid = 1'b0;
        cmt_d[i].valid = 1'b0;
      end
    end
    count_d = stage_valid_count(ex_d) + stage_valid_count(mem_d) + stage_valid_count(cmt_d);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      ex_q    <= '0;
      mem_q   <= '0;
      cmt_q   <= '0;
      count_q <= '0;
    end else begin
      ex_q    <= ex_d;
      mem_q   <= mem_d;
      cmt_q   <= cmt_d;
      count_q <= count_d;
    end
  end

  assign inflight_count = count_q;

  for (genvar q = 0; q < 4; q++) begin : g_lookup
    score_board_lookup u_lookup (
      .enable     (rst),
      .query_addr (query_addr[q]),
      .ex_stage   (ex_q),
      .mem_stage  (mem_q),
      .cmt_stage  (cmt_q),
      .result     (score_board_data[q])
    );
  end

endmodule

// File: tb/tb_score_board.sv
// tb/tb_score_board.sv - directed table-driven bench for score_board
module tb_score_board;
  import score_board_pkg::*;

  // Expected result encodings {src[1:0], slot, ready}
  localparam logic [3:0] RF   = 4'b0001;
  localparam logic [3:0] EX0  = 4'b0101;
  localparam logic [3:0] EX1  = 4'b0111;
  localparam logic [3:0] EXL0 = 4'b0100;
  localparam logic [3:0] EXL1 = 4'b0110;
  localparam logic [3:0] MEM0 = 4'b1001;
  localparam logic [3:0] MEM1 = 4'b1011;
  localparam logic [3:0] CMT0 = 4'b1101;
  localparam logic [3:0] CMT1 = 4'b1111;

  typedef struct {
    logic            rst_n;
    logic            flush;
    logic [1:0]      ena;
    logic [1:0]      wen;
    logic [1:0]      ld;
    logic [4:0]      d0;
    logic [4:0]      d1;
    logic [3:0][4:0] q;
    logic [3:0][3:0] exp;
    logic [2:0]      cnt;
  } vec_t;

  logic                    clk;
  logic                    rst;
  logic [1:0]              issue_ena;
  logic [1:0]              issue_wen;
  logic [1:0][4:0]         issue_dest;
  logic [1:0]              issue_is_load;
  logic                    flush;
  logic [3:0][4:0]         query_addr;
  score_board_data_t [3:0] score_board_data;
  logic [2:0]              inflight_count;

  int n_checks = 0;
  int n_pass   = 0;
  vec_t vecs[$];

  score_board dut (
    .clk              (clk),
    .rst              (rst),
    .issue_ena        (issue_ena),
    .issue_wen        (issue_wen),
    .issue_dest       (issue_dest),
    .issue_is_load    (issue_is_load),
    .flush            (flush),
    .query_addr       (query_addr),
    .score_board_data (score_board_data),
    .inflight_count   (inflight_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic add(input logic rst_n, input logic fl, input logic [1:0] ena, input logic [1:0] wen,
                     input logic [1:0] ld, input logic [4:0] d0, input logic [4:0] d1,
                     input logic [4:0] q0, input logic [4:0] q1, input logic [4:0] q2, input logic [4:0] q3,
                     input logic [3:0] e0, input logic [3:0] e1, input logic [3:0] e2, input logic [3:0] e3,
                     input logic [2:0] cnt);
    vec_t v;
    v.rst_n = rst_n; v.flush = fl; v.ena = ena; v.wen = wen; v.ld = ld; v.d0 = d0; v.d1 = d1;
    v.q   = {q3, q2, q1, q0};
    v.exp = {e3, e2, e1, e0};
    v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic check_outputs(input string tag, input logic [3:0][3:0] exp, input logic [2:0] cnt);
    for (int k = 0; k < 4; k++)
      chk($sformatf("%s data%0d", tag, k), {4'b0, score_board_data[k]}, {4'b0, exp[k]});
    chk($sformatf("%s count", tag), {5'b0, inflight_count}, {5'b0, cnt});
  endtask

  initial begin
    rst = 1'b0; flush = 1'b0; issue_ena = '0; issue_wen = '0; issue_dest = '0;
    issue_is_load = '0; query_addr = '0;

    //  rst fl ena    wen    ld     d0  d1   queries           expected                 cnt
    add(0, 0, 2'b00, 2'b00, 2'b00, 0,  0,   0, 5, 7, 9,       RF,   RF,   RF,   RF,   0);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   5, 7, 9, 3,       RF,   RF,   RF,   RF,   0);
    // single write to r5 walks EX -> MEM -> CMT -> regfile
    add(1, 0, 2'b01, 2'b01, 2'b00, 5,  0,   5, 0, 7, 3,       EX0,  RF,   RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   5, 0, 7, 3,       MEM0, RF,   RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   5, 5, 7, 3,       CMT0, CMT0, RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   5, 5, 7, 3,       RF,   RF,   RF,   RF,   0);
    // both slots write r7: slot 1 is younger and wins
    add(1, 0, 2'b11, 2'b11, 2'b00, 7,  7,   7, 5, 7, 0,       EX1,  RF,   EX1,  RF,   2);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   7, 5, 7, 0,       MEM1, RF,   MEM1, RF,   2);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   7, 5, 7, 0,       CMT1, RF,   CMT1, RF,   2);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   7, 5, 7, 0,       RF,   RF,   RF,   RF,   0);
    // load to r9 is not ready while in EX
    add(1, 0, 2'b01, 2'b01, 2'b01, 9,  0,   9, 9, 0, 5,       EXL0, EXL0, RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   9, 9, 0, 5,       MEM0, MEM0, RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   9, 9, 0, 5,       CMT0, CMT0, RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   9, 9, 0, 5,       RF,   RF,   RF,   RF,   0);
    // r3 rewritten the next cycle: newer EX entry shadows MEM
    add(1, 0, 2'b01, 2'b01, 2'b00, 3,  0,   3, 1, 2, 4,       EX0,  RF,   RF,   RF,   1);
    add(1, 0, 2'b10, 2'b10, 2'b00, 0,  3,   3, 1, 2, 4,       EX1,  RF,   RF,   RF,   2);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   3, 1, 2, 4,       MEM1, RF,   RF,   RF,   2);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   3, 1, 2, 4,       CMT1, RF,   RF,   RF,   1);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   3, 1, 2, 4,       RF,   RF,   RF,   RF,   0);
    // dest r0 with wen, and r4 without wen: neither tracked
    add(1, 0, 2'b11, 2'b01, 2'b00, 0,  4,   0, 4, 0, 4,       RF,   RF,   RF,   RF,   0);
    // fill all stages, then flush (with a competing issue)
    add(1, 0, 2'b11, 2'b11, 2'b10, 1,  2,   1, 2, 3, 4,       EX0,  EXL1, RF,   RF,   2);
    add(1, 0, 2'b11, 2'b11, 2'b00, 3,  4,   1, 2, 3, 4,       MEM0, MEM1, EX0,  EX1,  4);
    add(1, 0, 2'b11, 2'b11, 2'b00, 5,  6,   1, 4, 6, 2,       CMT0, MEM1, EX1,  CMT1, 6);
    add(1, 1, 2'b11, 2'b11, 2'b00, 8,  10,  1, 6, 8, 10,      RF,   RF,   RF,   RF,   0);
    // refill, then reset (with a competing issue)
    add(1, 0, 2'b11, 2'b11, 2'b00, 1,  2,   1, 2, 3, 4,       EX0,  EX1,  RF,   RF,   2);
    add(1, 0, 2'b11, 2'b11, 2'b00, 3,  4,   1, 2, 3, 4,       MEM0, MEM1, EX0,  EX1,  4);
    add(1, 0, 2'b11, 2'b11, 2'b00, 5,  6,   1, 3, 5, 2,       CMT0, MEM0, EX0,  CMT1, 6);
    add(0, 0, 2'b11, 2'b11, 2'b00, 8,  10,  1, 5, 8, 10,      RF,   RF,   RF,   RF,   0);
    add(1, 0, 2'b00, 2'b00, 2'b00, 0,  0,   1, 5, 8, 10,      RF,   RF,   RF,   RF,   0);

    foreach (vecs[i]) begin
      rst           = vecs[i].rst_n;
      flush         = vecs[i].flush;
      issue_ena     = vecs[i].ena;
      issue_wen     = vecs[i].wen;
      issue_is_load = vecs[i].ld;
      issue_dest    = {vecs[i].d1, vecs[i].d0};
      query_addr    = vecs[i].q;
      @(posedge clk);
      #1;
      check_outputs($sformatf("v%0d", i), vecs[i].exp, vecs[i].cnt);
    end

    // Load in slot 1 and plain write in slot 0 to the same register.
    rst = 1'b1; flush = 1'b0;
    issue_ena = 2'b11; issue_wen = 2'b11; issue_is_load = 2'b10;
    issue_dest = {5'd9, 5'd9};
    query_addr = {5'd0, 5'd0, 5'd0, 5'd9};
    @(posedge clk);
    #1;
    chk("seq load slot1", {4'b0, score_board_data[0]}, {4'b0, EXL1});
    // Lookup is combinational: changing the address alone changes the answer.
    issue_ena = 2'b00; issue_wen = 2'b00; issue_is_load = 2'b00;
    query_addr[0] = 5'd0;
    #1;
    chk("seq zero latency r0", {4'b0, score_board_data[0]}, {4'b0, RF});
    query_addr[0] = 5'd9;
    #1;
    chk("seq zero latency r9", {4'b0, score_board_data[0]}, {4'b0, EXL1});
    @(posedge clk);
    #1;
    chk("seq load in mem", {4'b0, score_board_data[0]}, {4'b0, MEM1});
    chk("seq count", {5'b0, inflight_count}, 8'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
